// File: rtl/voice_pkg.sv
// Shared types and constants for the voice allocator: FSM states, apply actions,
// the base increment table for notes 60..71 and small bit-count helpers.
package voice_pkg;

  localparam int NUM_VOICES = 4;
  localparam int INC_W      = 16;
  localparam int NOTE_W     = 7;
  localparam int RAMP_WRAP  = 60000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DIV      = 3'd1,
    ST_MATCH    = 3'd2,
    ST_APPLY    = 3'd3,
    ST_RELAUNCH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACT_FREE     = 2'd0,
    ACT_RELAUNCH = 2'd1,
    ACT_OFF      = 2'd2
  } act_t;

  // Increments for C..B in octave BASE_OCT; f_out is roughly 0.8 x inc
  localparam logic [INC_W-1:0] BASE_INC [12] = '{
    16'd327, 16'd346, 16'd367, 16'd389, 16'd412, 16'd437,
    16'd462, 16'd490, 16'd519, 16'd550, 16'd583, 16'd617
  };

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] first_set4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else if (v[3]) begin
      idx = 2'd3;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/note_inc_rom.sv
// Note-to-increment lookup: base increment for the semitone, scaled by
// octave relative to BASE_OCT (left shift above, right shift below).
module note_inc_rom
  import voice_pkg::*;
#(
  parameter logic [2:0] BASE_OCT = 3'd2
) (
  input  logic [3:0]  rem,
  input  logic [2:0]  oct,
  output logic [15:0] inc
);

  logic [15:0] base_s;

  // Table lookup followed by the octave shift
  always_comb begin
    base_s = 16'd0;
    inc    = 16'd0;
    if (rem < 4'd12) begin
      base_s = BASE_INC[rem];
    end else begin
      base_s = 16'd0;
    end
    if (oct >= BASE_OCT) begin
      inc = base_s << (oct - BASE_OCT);
    end else begin
      inc = base_s >> (BASE_OCT - oct);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Four-voice note allocator feeding the codec gates and increments.
// Define VOICE_STEAL_EN to steal the least-recently-used voice when all are busy.
module voice_allocator
  import voice_pkg::*;
#(
  parameter logic [6:0] NOTE_MIN = 7'd36,
  parameter logic [6:0] NOTE_MAX = 7'd95,
  parameter logic [2:0] BASE_OCT = 3'd2
) (
  input  logic        iCLK_18_4,
  input  logic        iRST_N,
  input  logic        iAll_off,
  input  logic        iEvt_valid,
  output logic        oEvt_ready,
  input  logic        iEvt_on,
  input  logic [6:0]  iEvt_note,
  output logic        key1_on,
  output logic        key2_on,
  output logic        key3_on,
  output logic        key4_on,
  output logic [15:0] sound1,
  output logic [15:0] sound2,
  output logic [15:0] sound3,
  output logic [15:0] sound4,
  output logic        oDrop,
  output logic [2:0]  oVoice_cnt
);

  state_t      state_r, state_nx_s;
  logic        on_r;
  logic [6:0]  note_r;
  logic [5:0]  rem_r;
  logic [2:0]  oct_r;
  logic [15:0] inc_r;
  logic [1:0]  tgt_r;
  act_t        act_r;

  logic [3:0]  key_r;
  logic [15:0] sound_r [4];
  logic [6:0]  tag_r   [4];
  logic [1:0]  rank_r  [4];
  logic        drop_r;
  logic        ready_r;
  logic [2:0]  cnt_r;

  logic        in_range_s;
  logic [15:0] rom_inc_s;
  logic [3:0]  hit_s;
  logic [3:0]  free_s;
  logic        sel_ok_s;
  logic        sel_drop_s;
  logic [1:0]  sel_idx_s;
  act_t        sel_act_s;

  assign in_range_s = (iEvt_note >= NOTE_MIN) && (iEvt_note <= NOTE_MAX);

  note_inc_rom #(.BASE_OCT(BASE_OCT)) u_rom (
    .rem (rem_r[3:0]),
    .oct (oct_r),
    .inc (rom_inc_s)
  );

  // Per-voice retrigger match and free flags
  always_comb begin
    hit_s  = 4'b0000;
    free_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      hit_s[i]  = key_r[i] && (tag_r[i] == note_r);
      free_s[i] = !key_r[i];
    end
  end

`ifdef VOICE_STEAL_EN
  logic [3:0] lru_s;

  // Oldest voice carries rank 3
  always_comb begin
    lru_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      lru_s[i] = (rank_r[i] == 2'd3);
    end
  end
`endif

  // Target voice selection for the latched event
  always_comb begin
    sel_ok_s   = 1'b0;
    sel_drop_s = 1'b0;
    sel_idx_s  = 2'd0;
    sel_act_s  = ACT_FREE;
    if (on_r) begin
      if (|hit_s) begin
        sel_ok_s  = 1'b1;
        sel_idx_s = first_set4(hit_s);
        sel_act_s = ACT_RELAUNCH;
      end else if (|free_s) begin
        sel_ok_s  = 1'b1;
        sel_idx_s = first_set4(free_s);
        sel_act_s = ACT_FREE;
      end else begin
`ifdef VOICE_STEAL_EN
        sel_ok_s  = 1'b1;
        sel_idx_s = first_set4(lru_s);
        sel_act_s = ACT_RELAUNCH;
`else
        sel_drop_s = 1'b1;
`endif
      end
    end else begin
      if (|hit_s) begin
        sel_ok_s  = 1'b1;
        sel_idx_s = first_set4(hit_s);
        sel_act_s = ACT_OFF;
      end else begin
        sel_ok_s = 1'b0;
      end
    end
  end

  // Next-state logic; panic forces IDLE
  always_comb begin
    state_nx_s = state_r;
    if (iAll_off) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iEvt_valid && in_range_s) begin
            state_nx_s = ST_DIV;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_DIV: begin
          if (rem_r >= 6'd12) begin
            state_nx_s = ST_DIV;
          end else begin
            state_nx_s = ST_MATCH;
          end
        end
        ST_MATCH: begin
          if (sel_ok_s) begin
            state_nx_s = ST_APPLY;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_APPLY: begin
          if (act_r == ACT_RELAUNCH) begin
            state_nx_s = ST_RELAUNCH;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_RELAUNCH: state_nx_s = ST_IDLE;
        default:     state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Event datapath and voice bookkeeping
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      on_r    <= 1'b0;
      note_r  <= 7'd0;
      rem_r   <= 6'd0;
      oct_r   <= 3'd0;
      inc_r   <= 16'd0;
      tgt_r   <= 2'd0;
      act_r   <= ACT_FREE;
      key_r   <= 4'b0000;
      drop_r  <= 1'b0;
      ready_r <= 1'b1;
      cnt_r   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        sound_r[i] <= 16'd0;
        tag_r[i]   <= 7'd0;
        rank_r[i]  <= 2'(i);
      end
    end else begin
      ready_r <= (state_nx_s == ST_IDLE);
      cnt_r   <= popcount4(key_r);
      drop_r  <= 1'b0;
      if (iAll_off) begin
        key_r <= 4'b0000;
        for (int i = 0; i < 4; i++) begin
          sound_r[i] <= 16'd0;
          rank_r[i]  <= 2'(i);
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (iEvt_valid) begin
              on_r   <= iEvt_on;
              note_r <= iEvt_note;
              rem_r  <= 6'(iEvt_note - NOTE_MIN);
              oct_r  <= 3'd0;
              drop_r <= !in_range_s;
            end
          end
          ST_DIV: begin
            if (rem_r >= 6'd12) begin
              rem_r <= rem_r - 6'd12;
              oct_r <= oct_r + 3'd1;
            end
          end
          ST_MATCH: begin
            inc_r  <= rom_inc_s;
            tgt_r  <= sel_idx_s;
            act_r  <= sel_act_s;
            drop_r <= sel_drop_s;
          end
          ST_APPLY: begin
            if (act_r == ACT_OFF) begin
              key_r[tgt_r] <= 1'b0;
            end else begin
              // Retrigger/steal drops the gate for one cycle to restart the ramp
              key_r[tgt_r]   <= (act_r == ACT_FREE);
              sound_r[tgt_r] <= inc_r;
              tag_r[tgt_r]   <= note_r;
              for (int i = 0; i < 4; i++) begin
                if (2'(i) == tgt_r) begin
                  rank_r[i] <= 2'd0;
                end else if (rank_r[i] < rank_r[tgt_r]) begin
                  rank_r[i] <= rank_r[i] + 2'd1;
                end
              end
            end
          end
          ST_RELAUNCH: key_r[tgt_r] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign oEvt_ready = ready_r;
  assign oDrop      = drop_r;
  assign oVoice_cnt = cnt_r;
  assign key1_on    = key_r[0];
  assign key2_on    = key_r[1];
  assign key3_on    = key_r[2];
  assign key4_on    = key_r[3];
  assign sound1     = sound_r[0];
  assign sound2     = sound_r[1];
  assign sound3     = sound_r[2];
  assign sound4     = sound_r[3];

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a reference model predicts output
// snapshots per event and a monitor compares them at their due cycle.
module tb_voice_allocator;

  logic        iCLK_18_4 = 1'b0;
  logic        iRST_N;
  logic        iAll_off;
  logic        iEvt_valid;
  logic        oEvt_ready;
  logic        iEvt_on;
  logic [6:0]  iEvt_note;
  logic        key1_on, key2_on, key3_on, key4_on;
  logic [15:0] sound1, sound2, sound3, sound4;
  logic        oDrop;
  logic [2:0]  oVoice_cnt;

  voice_allocator dut (
    .iCLK_18_4 (iCLK_18_4), .iRST_N (iRST_N), .iAll_off (iAll_off),
    .iEvt_valid (iEvt_valid), .oEvt_ready (oEvt_ready), .iEvt_on (iEvt_on),
    .iEvt_note (iEvt_note),
    .key1_on (key1_on), .key2_on (key2_on), .key3_on (key3_on), .key4_on (key4_on),
    .sound1 (sound1), .sound2 (sound2), .sound3 (sound3), .sound4 (sound4),
    .oDrop (oDrop), .oVoice_cnt (oVoice_cnt)
  );

  always #27 iCLK_18_4 = ~iCLK_18_4;

  int cyc = 0;
  always @(posedge iCLK_18_4) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  keys;
    logic [63:0] snd;
    logic        drop;
    logic        rdy;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int last_t;

  logic [3:0] m_key;
  int m_sound [4];
  int m_tag   [4];
  int m_rank  [4];
  int rom     [12] = '{327, 346, 367, 389, 412, 437, 462, 490, 519, 550, 583, 617};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs_keys();
    return {key4_on, key3_on, key2_on, key1_on};
  endfunction

  function automatic logic [63:0] obs_snd();
    return {sound4, sound3, sound2, sound1};
  endfunction

  function automatic int pop4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  function automatic int exp_inc(input int n);
    int r, o;
    r = (n - 36) % 12;
    o = (n - 36) / 12;
    if (o >= 2) return rom[r] << (o - 2);
    else        return rom[r] >> (2 - o);
  endfunction

  task automatic model_reset();
    m_key = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_sound[i] = 0;
      m_tag[i]   = -1;
      m_rank[i]  = i;
    end
  endtask

  task automatic push(input int due, input logic drop, input logic rdy);
    exp_t e;
    e.due  = due;
    e.keys = m_key;
    e.snd  = {16'(m_sound[3]), 16'(m_sound[2]), 16'(m_sound[1]), 16'(m_sound[0])};
    e.drop = drop;
    e.rdy  = rdy;
    sb.push_back(e);
  endtask

  // Compare every expected snapshot at the cycle it falls due
  always @(negedge iCLK_18_4) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("keys@%0d", e.due), 64'(obs_keys()), 64'(e.keys));
      chk($sformatf("snd@%0d", e.due), obs_snd(), e.snd);
      chk($sformatf("drop@%0d", e.due), 64'(oDrop), 64'(e.drop));
      chk($sformatf("rdy@%0d", e.due), 64'(oEvt_ready), 64'(e.rdy));
    end
  end

  task automatic wait_done();
    int k;
    k = 0;
    while ((sb.size() > 0 || !oEvt_ready) && k < 40) begin
      @(negedge iCLK_18_4); #1;
      k++;
    end
    if (k >= 40) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input bit on, input int note, input bit wait_en);
    int t, q, v, inc;
    bit relaunch;
    @(negedge iCLK_18_4); #1;
    chk("ready_before", 64'(oEvt_ready), 64'd1);
    iEvt_valid = 1'b1;
    iEvt_on    = on;
    iEvt_note  = 7'(note);
    t = cyc + 1;
    last_t = t;
    if (note < 36 || note > 95) begin
      push(t, 1'b1, 1'b1);
      push(t + 1, 1'b0, 1'b1);
    end else begin
      q = (note - 36) / 12;
      inc = exp_inc(note);
      v = -1;
      relaunch = 1'b0;
      for (int i = 3; i >= 0; i--) if (m_key[i] && m_tag[i] == note) v = i;
      if (on) begin
        if (v >= 0) relaunch = 1'b1;
        else for (int i = 3; i >= 0; i--) if (!m_key[i]) v = i;
        if (v < 0) begin
`ifdef VOICE_STEAL_EN
          for (int i = 0; i < 4; i++) if (m_rank[i] == 3) v = i;
          relaunch = 1'b1;
`else
          push(t + q + 2, 1'b1, 1'b1);
          push(t + q + 3, 1'b0, 1'b1);
`endif
        end
        if (v >= 0) begin
          for (int i = 0; i < 4; i++)
            if (i != v && m_rank[i] < m_rank[v]) m_rank[i]++;
          m_rank[v]  = 0;
          m_tag[v]   = note;
          m_sound[v] = inc;
          if (relaunch) begin
            m_key[v] = 1'b0;
            push(t + q + 3, 1'b0, 1'b0);
            m_key[v] = 1'b1;
            push(t + q + 4, 1'b0, 1'b1);
          end else begin
            m_key[v] = 1'b1;
            push(t + q + 3, 1'b0, 1'b1);
          end
        end
      end else begin
        if (v >= 0) begin
          m_key[v] = 1'b0;
          push(t + q + 3, 1'b0, 1'b1);
        end else begin
          push(t + q + 2, 1'b0, 1'b1);
        end
      end
    end
    @(posedge iCLK_18_4); #1;
    iEvt_valid = 1'b0;
    if (wait_en) wait_done();
  endtask

  task automatic chk_cnt(input string tag);
    @(negedge iCLK_18_4); #1;
    chk(tag, 64'(oVoice_cnt), 64'(pop4(m_key)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_keys"}, 64'(obs_keys()), 64'd0);
    chk({tag, "_snd"}, obs_snd(), 64'd0);
    chk({tag, "_drop"}, 64'(oDrop), 64'd0);
    chk({tag, "_ready"}, 64'(oEvt_ready), 64'd1);
  endtask

  initial begin
    iRST_N = 1'b0; iAll_off = 1'b0; iEvt_valid = 1'b0; iEvt_on = 1'b0; iEvt_note = 7'd0;
    model_reset();
    #100;
    @(negedge iCLK_18_4); iRST_N = 1'b1; #1;
    chk_all_zero("reset");
    chk("reset_cnt", 64'(oVoice_cnt), 64'd0);

    send(1'b1, 69, 1'b1); chk_cnt("cnt_one");
    send(1'b1, 45, 1'b1);
    send(1'b1, 81, 1'b1);
    send(1'b1, 95, 1'b1); chk_cnt("cnt_full");
    send(1'b1, 60, 1'b1); chk_cnt("cnt_busy");
    send(1'b0, 81, 1'b1);
    send(1'b0, 50, 1'b1); chk_cnt("cnt_off");
    send(1'b1, 95, 1'b1);
    send(1'b1, 30, 1'b1);
    send(1'b1, 100, 1'b1);

    // Panic while note 69 is still dividing
    @(negedge iCLK_18_4); #1;
    iEvt_valid = 1'b1; iEvt_on = 1'b1; iEvt_note = 7'd69;
    @(posedge iCLK_18_4); #1;
    iEvt_valid = 1'b0; iAll_off = 1'b1;
    @(posedge iCLK_18_4); #1;
    iAll_off = 1'b0;
    model_reset();
    chk_all_zero("alloff");
    for (int i = 0; i < 6; i++) begin
      @(negedge iCLK_18_4); #1;
      chk("alloff_quiet_drop", 64'(oDrop), 64'd0);
      chk("alloff_quiet_keys", 64'(obs_keys()), 64'd0);
    end
    chk("alloff_cnt", 64'(oVoice_cnt), 64'd0);

    // Asynchronous reset while a retrigger sits in RELAUNCH
    send(1'b1, 69, 1'b1);
    send(1'b1, 69, 1'b0);
    while (cyc < last_t + 5) begin
      @(negedge iCLK_18_4); #1;
    end
    iRST_N = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_cnt", 64'(oVoice_cnt), 64'd0);
    sb.delete();
    model_reset();
    @(negedge iCLK_18_4); iRST_N = 1'b1;
    send(1'b1, 81, 1'b1); chk_cnt("cnt_recover");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
